// File: rtl/vme_arb_pkg.sv
// Shared types and constants for the VME command arbiter.
package vme_arb_pkg;

    localparam int unsigned CMD_W      = 32;
    localparam int unsigned RSP_W      = 16;
    localparam int unsigned VME_RD_BIT = 25;
    localparam int unsigned VME_WR_BIT = 24;

    localparam logic [CMD_W-1:0] DEF_BASE_MASK = 32'h00A8_0000;
    localparam logic [RSP_W-1:0] TIMEOUT_DATA  = 16'hDEAD;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    // Command word as presented to the VME engine: mask plus direction bit.
    function automatic logic [CMD_W-1:0] vme_word(input logic [CMD_W-1:0] cmd,
                                                  input logic [CMD_W-1:0] mask,
                                                  input logic             rd);
        logic [CMD_W-1:0] w;
        w = cmd | mask;
        if (rd) w[VME_RD_BIT] = 1'b1;
        else    w[VME_WR_BIT] = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/vme_rr_pick.sv
// Combinational round-robin picker: first active request after 'last'.
module vme_rr_pick #(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] last,
    output logic [NREQ-1:0]         grant_c,
    output logic [$clog2(NREQ)-1:0] idx_c,
    output logic                    any_c
);

    localparam int unsigned IDXW = $clog2(NREQ);

    int unsigned j;

    always_comb begin
        grant_c = '0;
        idx_c   = '0;
        any_c   = 1'b0;
        j       = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            j = (32'(last) + k) % NREQ;
            if (!any_c && req[IDXW'(j)]) begin
                any_c               = 1'b1;
                grant_c[IDXW'(j)]   = 1'b1;
                idx_c               = IDXW'(j);
            end
        end
    end

endmodule

// File: rtl/vme_cmd_arbiter.sv
// Round-robin arbiter funnelling requester commands into one VME engine.
// Optional WAIT timeout enabled by defining VME_ARB_TIMEOUT_EN.
module vme_cmd_arbiter
    import vme_arb_pkg::*;
#(
    parameter int unsigned NREQ        = 4,
    parameter logic [31:0] BASE_MASK   = DEF_BASE_MASK,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*32-1:0] req_cmd,
    input  logic [NREQ*32-1:0] req_dat,
    input  logic [NREQ-1:0]    req_rd,
    output logic [NREQ-1:0]    req_ack,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [15:0]        rsp_data,
    output logic               rsp_err,
    output logic               start,
    output logic [31:0]        vme_cmd_reg,
    output logic [31:0]        vme_dat_reg_in,
    input  logic               vme_cmd_rd,
    input  logic               vme_dat_wr,
    input  logic [31:0]        vme_dat_reg_out
);

    localparam int unsigned IDXW = $clog2(NREQ);

    state_t           state;
    logic [IDXW-1:0]  gidx;
    logic [IDXW-1:0]  last_grant;
    logic [IDXW-1:0]  pick_idx;
    logic [NREQ-1:0]  pick_grant;
    logic             pick_any;
    logic [31:0]      sel_cmd;
    logic [31:0]      sel_dat;
    logic             sel_rd;
    logic             unused_dat_hi;

    assign unused_dat_hi = ^vme_dat_reg_out[31:16];

    vme_rr_pick #(.NREQ(NREQ)) u_pick (
        .req     (req_valid),
        .last    (last_grant),
        .grant_c (pick_grant),
        .idx_c   (pick_idx),
        .any_c   (pick_any)
    );

    // Mux the picked requester's payload.
    always_comb begin
        sel_cmd = '0;
        sel_dat = '0;
        sel_rd  = 1'b0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (IDXW'(i) == pick_idx) begin
                sel_cmd = req_cmd[i*32 +: 32];
                sel_dat = req_dat[i*32 +: 32];
                sel_rd  = req_rd[i];
            end
        end
    end

`ifdef VME_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] tcnt;
    logic             err_q;
    assign rsp_err = err_q;
`else
    localparam int unsigned unused_timeout_cyc = TIMEOUT_CYC;
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            start          <= 1'b0;
            vme_cmd_reg    <= BASE_MASK;
            vme_dat_reg_in <= '0;
            req_ack        <= '0;
            rsp_valid      <= '0;
            rsp_data       <= '0;
            gidx           <= IDXW'(NREQ - 1);
            last_grant     <= IDXW'(NREQ - 1);
`ifdef VME_ARB_TIMEOUT_EN
            tcnt           <= '0;
            err_q          <= 1'b0;
`endif
        end else begin
            req_ack   <= '0;
            rsp_valid <= '0;
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        req_ack        <= pick_grant;
                        gidx           <= pick_idx;
                        start          <= 1'b1;
                        vme_cmd_reg    <= vme_word(sel_cmd, BASE_MASK, sel_rd);
                        vme_dat_reg_in <= sel_dat;
                        state          <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (vme_cmd_rd) begin
                        start          <= 1'b0;
                        vme_cmd_reg    <= BASE_MASK;
                        vme_dat_reg_in <= '0;
                        state          <= ST_WAIT;
`ifdef VME_ARB_TIMEOUT_EN
                        tcnt           <= '0;
`endif
                    end
                end
                ST_WAIT: begin
                    if (vme_dat_wr) begin
                        rsp_data  <= vme_dat_reg_out[15:0];
                        rsp_valid <= NREQ'(1) << gidx;
                        state     <= ST_RESP;
`ifdef VME_ARB_TIMEOUT_EN
                        err_q     <= 1'b0;
                    end else if (tcnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        rsp_data  <= TIMEOUT_DATA;
                        rsp_valid <= NREQ'(1) << gidx;
                        err_q     <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        tcnt      <= tcnt + CNT_W'(1);
`endif
                    end
                end
                ST_RESP: begin
                    last_grant <= gidx;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vme_cmd_arbiter.sv
// Directed scoreboard bench for vme_cmd_arbiter (handles VME_ARB_TIMEOUT_EN either way).
module tb_vme_cmd_arbiter;

    localparam int unsigned NREQ = 4;
    localparam logic [31:0] MASK = 32'h00A8_0000;
    localparam int unsigned TO   = 16;

    logic               clk;
    logic               rst_n;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*32-1:0] req_cmd;
    logic [NREQ*32-1:0] req_dat;
    logic [NREQ-1:0]    req_rd;
    logic [NREQ-1:0]    req_ack;
    logic [NREQ-1:0]    rsp_valid;
    logic [15:0]        rsp_data;
    logic               rsp_err;
    logic               start;
    logic [31:0]        vme_cmd_reg;
    logic [31:0]        vme_dat_reg_in;
    logic               vme_cmd_rd;
    logic               vme_dat_wr;
    logic [31:0]        vme_dat_reg_out;

    vme_cmd_arbiter #(.NREQ(NREQ), .BASE_MASK(MASK), .TIMEOUT_CYC(TO)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_cmd         (req_cmd),
        .req_dat         (req_dat),
        .req_rd          (req_rd),
        .req_ack         (req_ack),
        .rsp_valid       (rsp_valid),
        .rsp_data        (rsp_data),
        .rsp_err         (rsp_err),
        .start           (start),
        .vme_cmd_reg     (vme_cmd_reg),
        .vme_dat_reg_in  (vme_dat_reg_in),
        .vme_cmd_rd      (vme_cmd_rd),
        .vme_dat_wr      (vme_dat_wr),
        .vme_dat_reg_out (vme_dat_reg_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [15:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word(input logic [31:0] cmd, input logic rd);
        return cmd | MASK | (rd ? 32'h0200_0000 : 32'h0100_0000);
    endfunction

    task automatic set_req(input int i, input logic [31:0] cmd, input logic [31:0] dat,
                           input logic rd);
        req_cmd[i*32 +: 32] = cmd;
        req_dat[i*32 +: 32] = dat;
        req_rd[i]           = rd;
    endtask

    // Grant, then optional ISSUE stall, then accept with a same-cycle stray vme_dat_wr.
    task automatic issue_phase(input int idx, input logic [31:0] exp_word,
                               input logic [31:0] exp_dat, input int stall, input bit drop);
        int n;
        n = 0;
        while (req_ack == '0 && n < 20) begin
            tick();
            n++;
        end
        chk("ack_grant", 32'(req_ack), 32'(1) << idx);
        if (drop) req_valid[idx] = 1'b0;
        chk("start_on_grant", 32'(start), 32'd1);
        chk("cmd_word", vme_cmd_reg, exp_word);
        chk("dat_word", vme_dat_reg_in, exp_dat);
        for (int s = 0; s < stall; s++) begin
            vme_dat_wr      = (s == 0);
            vme_dat_reg_out = 32'hFFFF_0BAD;
            tick();
            vme_dat_wr = 1'b0;
            chk("stall_ack_pulse", 32'(req_ack), 32'd0);
            chk("stall_start", 32'(start), 32'd1);
            chk("stall_cmd", vme_cmd_reg, exp_word);
        end
        vme_cmd_rd      = 1'b1;
        vme_dat_wr      = 1'b1;
        vme_dat_reg_out = 32'hFFFF_0BAD;
        tick();
        vme_cmd_rd = 1'b0;
        vme_dat_wr = 1'b0;
        chk("accept_start", 32'(start), 32'd0);
        chk("accept_cmd", vme_cmd_reg, MASK);
        chk("accept_dat", vme_dat_reg_in, 32'd0);
        chk("accept_no_rsp", 32'(rsp_valid), 32'd0);
    endtask

    task automatic check_rsp();
        exp_t e;
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("rsp_valid", 32'(rsp_valid), 32'(1) << e.idx);
            chk("rsp_data", 32'(rsp_data), 32'(e.data));
            chk("rsp_err", 32'(rsp_err), 32'(e.err));
        end
    endtask

    // WAIT for 'gap' cycles (optionally pulsing another requester), then complete.
    task automatic resp_phase(input int gap, input logic [31:0] rdata, input int pulse);
        bit ack_seen;
        ack_seen = 1'b0;
        if (pulse >= 0) begin
            req_valid[pulse] = 1'b1;
            tick();
            req_valid[pulse] = 1'b0;
        end
        for (int g = 0; g < gap; g++) tick();
        vme_dat_wr      = 1'b1;
        vme_dat_reg_out = rdata;
        tick();
        vme_dat_wr = 1'b0;
        check_rsp();
        tick();
        chk("rsp_pulse", 32'(rsp_valid), 32'd0);
        if (pulse >= 0) begin
            for (int k = 0; k < 5; k++) begin
                if (req_ack != '0) ack_seen = 1'b1;
                tick();
            end
            chk("withdrawn_no_ack", 32'(ack_seen), 32'd0);
        end
    endtask

    task automatic run_txn(input int idx, input logic [31:0] exp_word, input logic [31:0] exp_dat,
                           input int stall, input int gap, input logic [31:0] rdata,
                           input bit drop, input int pulse);
        sb.push_back('{idx, rdata[15:0], 1'b0});
        issue_phase(idx, exp_word, exp_dat, stall, drop);
        resp_phase(gap, rdata, pulse);
    endtask

    initial begin
        int  n;
        bit  seen;
        rst_n           = 1'b0;
        req_valid       = '0;
        req_cmd         = '0;
        req_dat         = '0;
        req_rd          = '0;
        vme_cmd_rd      = 1'b0;
        vme_dat_wr      = 1'b0;
        vme_dat_reg_out = '0;
        tick();
        tick();
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_cmd", vme_cmd_reg, MASK);
        chk("rst_dat", vme_dat_reg_in, 32'd0);
        chk("rst_ack", 32'(req_ack), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        rst_n = 1'b1;
        tick();

        // Read from requester 0, result three cycles after accept.
        set_req(0, 32'h0000_3000, 32'h0, 1'b1);
        req_valid[0] = 1'b1;
        run_txn(0, 32'h02A8_3000, 32'h0, 0, 2, 32'h0000_1234, 1'b1, -1);

        // Write from requester 2; requester 3 pulses briefly while busy.
        set_req(2, 32'h0000_4100, 32'h0000_BEEF, 1'b0);
        req_valid[2] = 1'b1;
        run_txn(2, 32'h01A8_4100, 32'h0000_BEEF, 0, 0, 32'h0000_5A5A, 1'b1, 3);

        // Ten-cycle stall in ISSUE.
        set_req(1, 32'h0000_0042, 32'h0, 1'b1);
        req_valid[1] = 1'b1;
        run_txn(1, 32'h02A8_0042, 32'h0, 10, 1, 32'hABCD_7777, 1'b1, -1);

        // No result from the engine.
        set_req(1, 32'h0000_0777, 32'h0, 1'b1);
        req_valid[1] = 1'b1;
`ifdef VME_ARB_TIMEOUT_EN
        sb.push_back('{1, 16'hDEAD, 1'b1});
`else
        sb.push_back('{1, 16'h0999, 1'b0});
`endif
        issue_phase(1, 32'h02A8_0777, 32'h0, 0, 1'b1);
        n = 0;
        while (rsp_valid == '0 && n < 40) begin
            tick();
            n++;
        end
`ifdef VME_ARB_TIMEOUT_EN
        chk("timeout_cycles", 32'(n), 32'(TO));
        check_rsp();
        tick();
        chk("timeout_rsp_pulse", 32'(rsp_valid), 32'd0);
`else
        chk("no_timeout_rsp", 32'(rsp_valid), 32'd0);
        chk("no_timeout_start", 32'(start), 32'd0);
        resp_phase(0, 32'h0000_0999, -1);
`endif

        // Asynchronous reset while waiting for the result.
        set_req(2, 32'h0000_0222, 32'h0000_2222, 1'b0);
        req_valid[2] = 1'b1;
        issue_phase(2, 32'h01A8_0222, 32'h0000_2222, 0, 1'b1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("arst_start", 32'(start), 32'd0);
        chk("arst_cmd", vme_cmd_reg, MASK);
        chk("arst_dat", vme_dat_reg_in, 32'd0);
        chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("arst_rsp_data", 32'(rsp_data), 32'd0);
        chk("arst_rsp_err", 32'(rsp_err), 32'd0);
        vme_dat_wr      = 1'b1;
        vme_dat_reg_out = 32'h0000_1357;
        tick();
        tick();
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k == 2) vme_dat_wr = 1'b0;
            tick();
            if (rsp_valid != '0 || req_ack != '0) seen = 1'b1;
        end
        chk("post_reset_silent", 32'(seen), 32'd0);

        // All requesters held high: strict rotation from index 0.
        for (int i = 0; i < int'(NREQ); i++)
            set_req(i, 32'(i + 1) << 8, 32'h1111 * 32'(i + 1), (i % 2) == 1);
        req_valid = '1;
        for (int t = 0; t < 5; t++) begin
            int i;
            i = t % int'(NREQ);
            run_txn(i, word(32'(i + 1) << 8, (i % 2) == 1), 32'h1111 * 32'(i + 1),
                    0, 0, 32'h0000_C000 + 32'(t), 1'b0, -1);
        end
        req_valid = '0;
        tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vme_cmd_arbiter.md
VME_CMD_ARBITER -- requirements
Module: vme_cmd_arbiter

Interface
REQ-001 NREQ, 4, number of command requesters (2..8).
REQ-002 BASE_MASK, 32'h00A80000, OR'd into every issued VME command word.
REQ-003 TIMEOUT_CYC, 1024, maximum WAIT cycles before a forced error response.
REQ-004 clk  in  1  single system clock, all logic rising-edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 req_valid  in  NREQ  per-requester command request; held until acked.
REQ-007 req_cmd  in  NREQ*32  packed command words, requester i at [32i+31:32i].
REQ-008 req_dat  in  NREQ*32  packed write data words.
REQ-009 req_rd  in  NREQ  1=read, 0=write.
REQ-010 req_ack  out  NREQ  one-hot, one-cycle pulse on grant.
REQ-011 rsp_valid  out  NREQ  one-hot, one-cycle pulse on completion.
REQ-012 rsp_data  out  16  response data, valid with rsp_valid.
REQ-013 rsp_err  out  1  timeout flag, valid with rsp_valid.
REQ-014 start  out  1  command present to VME engine.
REQ-015 vme_cmd_reg  out  32  command word to VME engine.
REQ-016 vme_dat_reg_in  out  32  write data to VME engine.
REQ-017 vme_cmd_rd  in  1  VME engine accepts command this cycle.
REQ-018 vme_dat_wr  in  1  VME engine result valid this cycle.
REQ-019 vme_dat_reg_out  in  32  VME engine result data.

Function
REQ-020 FSM states IDLE, ISSUE, WAIT, RESP; all outputs registered.
REQ-021 IDLE: any req_valid -> round-robin pick starting at last_grant+1 mod NREQ; latch cmd/dat/rd; req_ack[i]=1 and start=1 on next cycle; go ISSUE.
REQ-022 ISSUE: vme_cmd_reg = cmd | BASE_MASK | bit25 (read) or bit24 (write); vme_dat_reg_in = dat; both stable while start=1.
REQ-023 ISSUE exits on first cycle vme_cmd_rd=1 sampled; next cycle start=0, vme_cmd_reg=BASE_MASK, vme_dat_reg_in=0, state WAIT.
REQ-024 WAIT: on vme_dat_wr=1 capture vme_dat_reg_out[15:0] into rsp_data, rsp_err=0, go RESP.
REQ-025 vme_dat_wr outside WAIT (incl. same cycle as vme_cmd_rd) is ignored.
REQ-026 RESP: rsp_valid[grant]=1 for exactly one cycle; last_grant updated; return IDLE.
REQ-027 Latency: req_valid sampled in IDLE at cycle N -> start=1 at N+1; vme_dat_wr at M -> rsp_valid at M+1; min 4 cycles per transaction.
REQ-028 req_valid deasserted before ack withdraws request without side effect; req_valid during own transaction is not re-granted until IDLE.
REQ-029 Single requester active: repeated grants to same index allowed.

Reset
REQ-030 rst_n low: state IDLE, start=0, vme_cmd_reg=BASE_MASK, vme_dat_reg_in=0, req_ack=0, rsp_valid=0, rsp_data=0, rsp_err=0, last_grant=NREQ-1, timeout counter 0.
REQ-031 Reset mid-transaction drops it silently; no rsp_valid issued for it after release.

Configuration
REQ-032 Macro VME_ARB_TIMEOUT_EN defined: WAIT counter increments per cycle; reaching TIMEOUT_CYC without vme_dat_wr -> RESP with rsp_err=1, rsp_data=16'hDEAD.
REQ-033 Macro undefined: no counter instantiated, WAIT unbounded, rsp_err tied 0.

Structure
REQ-034 Package vme_arb_pkg holds state enum, VME_RD_BIT=25, VME_WR_BIT=24, default mask 32'h00A80000, timeout data 16'hDEAD.
REQ-035 Sub-module vme_rr_pick: combinational round-robin picker (req vector, last_grant in; one-hot grant, index out).

Verification
REQ-036 Req0 read cmd 32'h00003000; vme_cmd_rd=1; vme_dat_wr 3 cycles later with 32'h00001234 -> vme_cmd_reg 32'h02A83000 one cycle, rsp_valid[0], rsp_data 16'h1234.
REQ-037 Req2 write cmd 32'h00004100 dat 32'h0000BEEF -> vme_cmd_reg 32'h01A84100, vme_dat_reg_in 32'h0000BEEF, rsp_valid[2].
REQ-038 All four req_valid held high -> grant order 0,1,2,3,0; no requester skipped.
REQ-039 vme_cmd_rd low 10 cycles in ISSUE -> start and vme_cmd_reg stable 10 cycles; accept on first high cycle.
REQ-040 TIMEOUT_CYC=16, no vme_dat_wr -> with macro rsp_err=1, rsp_data 16'hDEAD after 16 WAIT cycles; without macro stays WAIT.
REQ-041 rst_n low during WAIT -> all outputs at reset values asynchronously; no rsp_valid after release.
